// File: rtl/imm_operand_encoder.sv
// imm_operand_encoder: searches for the 12-bit shift_oprand field that the Val2
// operand generator expands back into a given 32-bit constant. Data mode tries one
// even rotation per clock (smallest rotation wins). Memory mode resolves in a
// single cycle as a 12-bit sign-extended offset.
module imm_operand_encoder #(
    parameter int unsigned ROT_STEPS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        mem_en_i,
    input  logic [31:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        found_o,
    output logic [11:0] shift_oprand_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic        mem_q, mem_d;
    logic [3:0]  rot_q, rot_d;
    logic        found_q, found_d;
    logic [11:0] shift_q, shift_d;

    logic [4:0]  rot_amt;
    logic [31:0] cand;
    logic        data_hit;
    logic        mem_hit;

    // Candidate for the current rotation and the hit tests for both modes.
    always_comb begin
        rot_amt  = {rot_q, 1'b0};
        cand     = (val_q << rot_amt) | (val_q >> (6'd32 - {1'b0, rot_amt}));
        data_hit = (cand[31:8] == '0);
        mem_hit  = (val_q[31:11] == '0) || (val_q[31:11] == '1);
    end

    // Next-state and datapath updates; results only change when a search resolves.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        mem_d   = mem_q;
        rot_d   = rot_q;
        found_d = found_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    val_d   = value_i;
                    mem_d   = mem_en_i;
                    rot_d   = '0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (mem_q) begin
                    state_d = S_DONE;
                    found_d = mem_hit;
                    shift_d = mem_hit ? val_q[11:0] : '0;
                end else if (data_hit) begin
                    state_d = S_DONE;
                    found_d = 1'b1;
                    shift_d = {rot_q, cand[7:0]};
                end else if (rot_q == ROT_LAST) begin
                    state_d = S_DONE;
                    found_d = 1'b0;
                    shift_d = '0;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            mem_q   <= 1'b0;
            rot_q   <= '0;
            found_q <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mem_q   <= mem_d;
            rot_q   <= rot_d;
            found_q <= found_d;
            shift_q <= shift_d;
        end
    end

    assign busy_o         = (state_q == S_SEARCH);
    assign done_o         = (state_q == S_DONE);
    assign found_o        = found_q;
    assign shift_oprand_o = shift_q;

endmodule
